// File: rtl/fifo_mem.sv
// fifo_mem: DEPTH x DBITS register array backing the FWFT FIFO.
// One synchronous write port and one asynchronous read port, so the head
// entry is visible combinationally on rdata. Storage is never reset.
module fifo_mem #(
  parameter int DBITS = 8,
  parameter int ABITS = 5
) (
  input  logic             clk,
  input  logic             we,
  input  logic [ABITS-1:0] waddr,
  input  logic [DBITS-1:0] wdata,
  input  logic [ABITS-1:0] raddr,
  output logic [DBITS-1:0] rdata
);

  localparam int DEPTH = 2 ** ABITS;

  logic [DBITS-1:0] mem [DEPTH];

  // Synchronous write of one word per accepted push.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/fifo.sv
// fifo: single-clock first-word-fall-through FIFO with status flags.
// dout always presents the oldest entry; the consumer samples it in the
// same cycle it asserts rd. Flags decode the registered count, so they
// change in the cycle after the edge that caused them.
// Optional build macro FIFO_ERR_FLAGS_EN adds sticky overflow/underflow
// outputs that record illegal pushes (full, no pop) and pops (empty).
module fifo #(
  parameter int DBITS    = 8,
  parameter int ABITS    = 5,
  parameter int AF_LEVEL = (2 ** ABITS) - 2,
  parameter int AE_LEVEL = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr,
  input  logic             rd,
  input  logic [DBITS-1:0] din,
  output logic [DBITS-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic             almost_full,
`ifdef FIFO_ERR_FLAGS_EN
  output logic             almost_empty,
  output logic             overflow,
  output logic             underflow
`else
  output logic             almost_empty
`endif
);

  localparam int              DEPTH    = 2 ** ABITS;
  localparam logic [ABITS:0]  DEPTH_C  = (ABITS + 1)'(DEPTH);
  localparam logic [ABITS:0]  AF_C     = (ABITS + 1)'(AF_LEVEL);
  localparam logic [ABITS:0]  AE_C     = (ABITS + 1)'(AE_LEVEL);
  localparam logic [ABITS:0]  ONE_C    = (ABITS + 1)'(1);
  localparam logic [ABITS-1:0] PTR_ONE = ABITS'(1);

  logic [ABITS-1:0] wr_ptr;
  logic [ABITS-1:0] rd_ptr;
  logic [ABITS:0]   count;
  logic             wr_acc;
  logic             rd_acc;

  // A push into a full FIFO is legal only when a pop frees the head slot
  // in the same cycle; an empty FIFO never pops, even with a push pending.
  assign wr_acc = wr & (~full | rd);
  assign rd_acc = rd & ~empty;

  assign full         = (count == DEPTH_C);
  assign empty        = (count == '0);
  assign almost_full  = (count >= AF_C);
  assign almost_empty = (count <= AE_C);

  // Pointer and occupancy state; reset discards all contents at once.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_acc) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (rd_acc) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      case ({wr_acc, rd_acc})
        2'b10:   count <= count + ONE_C;
        2'b01:   count <= count - ONE_C;
        default: count <= count;
      endcase
    end
  end

`ifdef FIFO_ERR_FLAGS_EN
  // Sticky records of requests that were dropped; cleared only by reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      overflow  <= overflow  | (wr & full & ~rd);
      underflow <= underflow | (rd & empty);
    end
  end
`endif

  fifo_mem #(
    .DBITS (DBITS),
    .ABITS (ABITS)
  ) u_mem (
    .clk   (clk),
    .we    (wr_acc),
    .waddr (wr_ptr),
    .wdata (din),
    .raddr (rd_ptr),
    .rdata (dout)
  );

endmodule

// File: tb/tb_fifo.sv
// tb_fifo: directed vector table plus hand-written multi-cycle sequences
// for the FWFT FIFO at DBITS=26, ABITS=5.
module tb_fifo;

  localparam int DBITS = 26;
  localparam int ABITS = 5;
  localparam int DEPTH = 32;

  logic             clk;
  logic             reset;
  logic             wr;
  logic             rd;
  logic [DBITS-1:0] din;
  logic [DBITS-1:0] dout;
  logic             full;
  logic             empty;
  logic             almost_full;
  logic             almost_empty;
`ifdef FIFO_ERR_FLAGS_EN
  logic             overflow;
  logic             underflow;
`endif

  int n_cmp;
  int n_bad;

  logic [DBITS-1:0] q [$];

  fifo #(
    .DBITS (DBITS),
    .ABITS (ABITS)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .wr           (wr),
    .rd           (rd),
    .din          (din),
    .dout         (dout),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
`ifdef FIFO_ERR_FLAGS_EN
    .almost_empty (almost_empty),
    .overflow     (overflow),
    .underflow    (underflow)
`else
    .almost_empty (almost_empty)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic             wr;
    logic             rd;
    logic [DBITS-1:0] din;
    logic             e_empty;
    logic             e_full;
    logic             e_af;
    logic             e_ae;
    logic             chk_dout;
    logic [DBITS-1:0] e_dout;
  } vec_t;

  vec_t vt [13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Check all four flags against an expected occupancy.
  task automatic check_flags(input string name, input int cnt);
    check({name, ".empty"}, 32'(empty), 32'(cnt == 0));
    check({name, ".full"}, 32'(full), 32'(cnt == DEPTH));
    check({name, ".af"}, 32'(almost_full), 32'(cnt >= DEPTH - 2));
    check({name, ".ae"}, 32'(almost_empty), 32'(cnt <= 2));
  endtask

  // Drive inputs at the falling edge, let one rising edge pass, return at the next falling edge.
  task automatic step(input logic w, input logic r, input logic [DBITS-1:0] d);
    wr  = w;
    rd  = r;
    din = d;
    @(posedge clk);
    @(negedge clk);
    wr  = 1'b0;
    rd  = 1'b0;
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    wr    = 1'b0;
    rd    = 1'b0;
    din   = '0;
    reset = 1'b0;

    //            wr    rd    din           empty full  af    ae    chk   dout
    vt[0]  = '{1'b0, 1'b1, 26'h0,       1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 26'h0};
    vt[1]  = '{1'b0, 1'b0, 26'h0,       1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 26'h0};
    vt[2]  = '{1'b1, 1'b0, 26'h0000008, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 26'h0};
    vt[3]  = '{1'b1, 1'b0, 26'h0000010, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 26'h0000008};
    vt[4]  = '{1'b1, 1'b0, 26'h0000018, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 26'h0000008};
    vt[5]  = '{1'b0, 1'b1, 26'h0,       1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 26'h0000008};
    vt[6]  = '{1'b0, 1'b1, 26'h0,       1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 26'h0000010};
    vt[7]  = '{1'b0, 1'b1, 26'h0,       1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 26'h0000018};
    vt[8]  = '{1'b0, 1'b0, 26'h0,       1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 26'h0};
    vt[9]  = '{1'b1, 1'b1, 26'h0000055, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 26'h0};
    vt[10] = '{1'b0, 1'b0, 26'h0,       1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 26'h0000055};
    vt[11] = '{1'b0, 1'b1, 26'h0,       1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 26'h0000055};
    vt[12] = '{1'b0, 1'b0, 26'h0,       1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 26'h0};

    repeat (2) @(negedge clk);
    check_flags("reset", 0);
    reset = 1'b1;
    @(negedge clk);

    // Table: outputs are checked before each vector's edge, reflecting earlier vectors.
    for (int i = 0; i < 13; i++) begin
      check($sformatf("vec%0d.empty", i), 32'(empty), 32'(vt[i].e_empty));
      check($sformatf("vec%0d.full", i), 32'(full), 32'(vt[i].e_full));
      check($sformatf("vec%0d.af", i), 32'(almost_full), 32'(vt[i].e_af));
      check($sformatf("vec%0d.ae", i), 32'(almost_empty), 32'(vt[i].e_ae));
      if (vt[i].chk_dout) begin
        check($sformatf("vec%0d.dout", i), 32'(dout), 32'(vt[i].e_dout));
      end
      step(vt[i].wr, vt[i].rd, vt[i].din);
    end

    // Fill 0..31, watch almost_full and full rise.
    for (int k = 0; k < DEPTH; k++) begin
      step(1'b1, 1'b0, DBITS'(k));
      check_flags($sformatf("fill%0d", k + 1), k + 1);
    end
    step(1'b1, 1'b0, DBITS'(99));
    check_flags("fill_over", DEPTH);
    for (int k = 0; k < DEPTH; k++) begin
      check($sformatf("drain%0d", k), 32'(dout), 32'(k));
      step(1'b0, 1'b1, '0);
    end
    check_flags("drained", 0);

    // Simultaneous push/pop with 5 preloaded for 100 cycles; pointers wrap.
    q.delete();
    for (int k = 0; k < 5; k++) begin
      step(1'b1, 1'b0, DBITS'(100 + k));
      q.push_back(DBITS'(100 + k));
    end
    for (int j = 0; j < 100; j++) begin
      if (j % 10 == 0) begin
        check($sformatf("rw%0d.dout", j), 32'(dout), 32'(q[0]));
      end
      step(1'b1, 1'b1, DBITS'(200 + j));
      void'(q.pop_front());
      q.push_back(DBITS'(200 + j));
    end
    check_flags("rw_end", 5);
    for (int k = 0; k < 5; k++) begin
      check($sformatf("rw_drain%0d", k), 32'(dout), 32'(q[0]));
      void'(q.pop_front());
      step(1'b0, 1'b1, '0);
    end
    check_flags("rw_drained", 0);

    // Push and pop together while full: oldest replaced, count stays 32.
    q.delete();
    for (int k = 0; k < DEPTH; k++) begin
      step(1'b1, 1'b0, DBITS'(300 + k));
      q.push_back(DBITS'(300 + k));
    end
    check_flags("full_pre", DEPTH);
    check("full_rw.pop", 32'(dout), 32'(300));
    step(1'b1, 1'b1, DBITS'(999));
    void'(q.pop_front());
    q.push_back(DBITS'(999));
    check_flags("full_rw", DEPTH);
    for (int k = 0; k < DEPTH; k++) begin
      if (k < 2 || k > DEPTH - 3) begin
        check($sformatf("full_drain%0d", k), 32'(dout), 32'(q[0]));
      end
      void'(q.pop_front());
      step(1'b0, 1'b1, '0);
    end
    check_flags("full_drained", 0);

    // Reset mid-stream with 10 entries: flags clear without waiting for an edge.
    for (int k = 0; k < 10; k++) begin
      step(1'b1, 1'b0, DBITS'(500 + k));
    end
    check_flags("pre_rst", 10);
    reset = 1'b0;
    #1;
    check_flags("mid_rst", 0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    step(1'b1, 1'b0, 26'h123);
    check_flags("post_rst", 1);
    check("post_rst.dout", 32'(dout), 32'h123);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fifo.md
Name: fifo

Overview:
- Synchronous single-clock first-word-fall-through (FWFT) FIFO.
- Used as the outstanding-request address queue in the VGA bus master: push an address on each bus read issued, pop on each read-data-valid beat.
- dout always presents the oldest entry combinationally, so the consumer samples dout in the same cycle it asserts rd.
- Provides full, empty, almost_full and almost_empty status.

Parameters:
- DBITS, 8, data width in bits (the VGA master uses 26).
- ABITS, 5, address width; DEPTH = 2**ABITS entries (32).
- AF_LEVEL, DEPTH-2, almost_full asserts when count >= AF_LEVEL.
- AE_LEVEL, 2, almost_empty asserts when count <= AE_LEVEL.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- wr  in  1  push din this cycle.
- rd  in  1  pop the head entry this cycle.
- din  in  DBITS  write data.
- dout  out  DBITS  head entry, combinational from storage; valid only while empty=0.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- almost_full  out  1  count >= AF_LEVEL.
- almost_empty  out  1  count <= AE_LEVEL.

Behaviour:
- State: wr_ptr and rd_ptr (ABITS each, wrap modulo DEPTH), count (ABITS+1 bits), storage array of DEPTH x DBITS. Storage is not reset.
- Reset: while reset=0, wr_ptr=0, rd_ptr=0, count=0, giving empty=1, almost_empty=1, full=0, almost_full=0. dout is don't-care after reset. Reset asserted mid-operation discards all contents immediately.
- Flags are combinational decodes of the registered count; they update in the cycle after the causing edge.
- Write accepted: wr & (!full | rd). The write stores din at wr_ptr on the clock edge, then wr_ptr advances.
- Read accepted: rd & !empty. rd_ptr advances on the clock edge; dout shows the next entry in the following cycle.
- Write latency: a word written into an empty FIFO appears on dout, with empty=0, one cycle after the write edge.
- count update: count + write_accepted - read_accepted.
- wr when full without rd: write ignored, contents unchanged.
- rd when empty: ignored, pointers unchanged. A simultaneous wr on an empty FIFO is still accepted; the write does not bypass to dout in the same cycle.
- wr & rd when full: both accepted, count stays DEPTH, the oldest entry is replaced in order.
- wr & rd when neither full nor empty: both accepted, count unchanged.
- Pointer wrap: wr_ptr and rd_ptr roll from DEPTH-1 to 0 with no data loss.

Optional Feature:
- Macro FIFO_ERR_FLAGS_EN. When defined, add two outputs:
  - overflow (1 bit): set on any cycle with wr & full & !rd.
  - underflow (1 bit): set on any cycle with rd & empty.
- Both are sticky and clear only on reset (reset value 0).
- When the macro is undefined, these ports and their logic are absent; illegal requests are silently ignored as described in Behaviour.

Decomposition:
- No shared package needed; all sizing is via parameters. DEPTH is a localparam computed from ABITS.
- One sub-module, fifo_mem: DEPTH x DBITS register array with one synchronous write port and one asynchronous read port.
- Pointer, count and flag logic live in fifo.

Test Plan:
- Reset then idle: empty=1, almost_empty=1, full=0, almost_full=0; rd=1 keeps count at 0.
- DBITS=26: write 0x0000008, 0x0000010, 0x0000018 on consecutive cycles, then rd each cycle. dout reads 0x8, 0x10, 0x18 in order, and empty returns to 1 after the third pop.
- Fill test: write 32 entries (values 0..31).
  - almost_full rises after entry 30 is written.
  - full rises after entry 32 is written.
  - A further wr of 99 is ignored; draining yields 0..31 with no 99.
- Simultaneous rd & wr: hold rd & wr for 100 cycles with 5 entries preloaded. count stays 5, pointers wrap past 31, and output order is preserved.
- Simultaneous rd & wr while full: count stays 32 and the popped value equals the oldest entry.
- Assert reset mid-stream with 10 entries: flags return to reset values within the same cycle, and a subsequent write of 0x123 reads back 0x123 as the first entry.
